// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl_if
// Brief    : Instruction, ALU request/result and result handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_issue_ctrl_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] rs1_dat;
  logic [31:0] rs2_dat;

  logic        dat_ready;
  logic [31:0] ALU_dat1;
  logic [31:0] ALU_dat2;
  logic [2:0]  ALU_opcode;
  logic        ALU_opcode_differentiator;
  logic        ALU_optype;

  logic [31:0] ALU_out;
  logic        ALU_overflow;
  logic        ALU_zero;
  logic        ALU_con_met;

  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_rd;
  logic        res_wb_en;
  logic        res_branch_taken;
  logic        res_overflow;
  logic        res_zero;
  logic        res_illegal;

  // slave: the issue controller itself
  modport slave (
    input  instr_valid, instr, rs1_dat, rs2_dat,
    input  ALU_out, ALU_overflow, ALU_zero, ALU_con_met,
    input  res_ready,
    output instr_ready,
    output dat_ready, ALU_dat1, ALU_dat2, ALU_opcode, ALU_opcode_differentiator, ALU_optype,
    output res_valid, res_data, res_rd, res_wb_en, res_branch_taken, res_overflow, res_zero,
    output res_illegal
  );

  // master: decode stage, ALU and writeback side
  modport master (
    output instr_valid, instr, rs1_dat, rs2_dat,
    output ALU_out, ALU_overflow, ALU_zero, ALU_con_met,
    output res_ready,
    input  instr_ready,
    input  dat_ready, ALU_dat1, ALU_dat2, ALU_opcode, ALU_opcode_differentiator, ALU_optype,
    input  res_valid, res_data, res_rd, res_wb_en, res_branch_taken, res_overflow, res_zero,
    input  res_illegal
  );
endinterface
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Brief    : Decodes R/I/B instructions, issues one fixed-latency ALU request,
//            and returns a registered result through a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
  parameter int ALU_LATENCY = 3
) (
  input wire logic       soc_clk,
  input wire logic       reset_b,
  alu_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [6:0] c_OP_R    = 7'b0110011;
  localparam logic [6:0] c_OP_I    = 7'b0010011;
  localparam logic [6:0] c_OP_B    = 7'b1100011;
  localparam logic [6:0] c_F7_ALT  = 7'b0100000;
  localparam logic [3:0] c_LATENCY = 4'(ALU_LATENCY);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_instr_ready;
  logic        r_dat_ready;
  logic [31:0] r_alu_dat1;
  logic [31:0] r_alu_dat2;
  logic [2:0]  r_alu_opcode;
  logic        r_alu_diff;
  logic        r_alu_optype;
  logic        r_is_branch;
  logic [4:0]  r_rd;
  logic        r_res_valid;
  logic [31:0] r_res_data;
  logic [4:0]  r_res_rd;
  logic        r_res_wb_en;
  logic        r_res_branch_taken;
  logic        r_res_overflow;
  logic        r_res_zero;
  logic        r_res_illegal;

  logic [31:0] w_instr;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic        w_is_r;
  logic        w_is_i;
  logic        w_is_b;
  logic        w_is_shift;
  logic        w_legal;
  logic [31:0] w_dat2;
  logic        w_diff;
  logic        w_xfer;
  logic        w_unused_rs1_field;

  assign w_instr            = bus.instr;
  assign w_opcode           = w_instr[6:0];
  assign w_funct3           = w_instr[14:12];
  assign w_funct7           = w_instr[31:25];
  assign w_unused_rs1_field = ^w_instr[19:15];

  assign w_is_r     = (w_opcode == c_OP_R);
  assign w_is_i     = (w_opcode == c_OP_I);
  assign w_is_b     = (w_opcode == c_OP_B);
  assign w_is_shift = w_is_i && ((w_funct3 == 3'b001) || (w_funct3 == 3'b101));

  always_comb begin
    w_legal = 1'b0;
    if (w_is_r) begin
      w_legal = (w_funct7 == 7'd0) ||
                ((w_funct7 == c_F7_ALT) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
    end else if (w_is_i) begin
      case (w_funct3)
        3'b001:  w_legal = (w_funct7 == 7'd0);
        3'b101:  w_legal = (w_funct7 == 7'd0) || (w_funct7 == c_F7_ALT);
        default: w_legal = 1'b1;
      endcase
    end else if (w_is_b) begin
      w_legal = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
    end
  end

  // Shift amounts are unsigned; every other immediate is sign-extended.
  assign w_dat2 = !w_is_i    ? bus.rs2_dat :
                  w_is_shift ? {27'd0, w_instr[24:20]} :
                               {{20{w_instr[31]}}, w_instr[31:20]};

  // ADDI shares funct3 000 with ADD/SUB but must never select subtract.
  assign w_diff = ((w_is_r && (w_funct3 == 3'b000)) ||
                   ((w_is_r || w_is_i) && (w_funct3 == 3'b101))) ? w_instr[30] : 1'b0;

  assign w_xfer = (r_state == S_IDLE) && r_instr_ready && bus.instr_valid;

  always_ff @(posedge soc_clk or posedge reset_b) begin
    if (reset_b) begin
      r_state            <= S_IDLE;
      r_cnt              <= 4'd0;
      r_instr_ready      <= 1'b0;
      r_dat_ready        <= 1'b0;
      r_alu_dat1         <= 32'd0;
      r_alu_dat2         <= 32'd0;
      r_alu_opcode       <= 3'd0;
      r_alu_diff         <= 1'b0;
      r_alu_optype       <= 1'b0;
      r_is_branch        <= 1'b0;
      r_rd               <= 5'd0;
      r_res_valid        <= 1'b0;
      r_res_data         <= 32'd0;
      r_res_rd           <= 5'd0;
      r_res_wb_en        <= 1'b0;
      r_res_branch_taken <= 1'b0;
      r_res_overflow     <= 1'b0;
      r_res_zero         <= 1'b0;
      r_res_illegal      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_instr_ready <= 1'b1;
          if (w_xfer) begin
            r_instr_ready <= 1'b0;
            if (w_legal) begin
              r_state      <= S_BUSY;
              r_cnt        <= c_LATENCY;
              r_dat_ready  <= 1'b1;
              r_alu_dat1   <= bus.rs1_dat;
              r_alu_dat2   <= w_dat2;
              r_alu_opcode <= w_funct3;
              r_alu_diff   <= w_diff;
              r_alu_optype <= w_is_b;
              r_is_branch  <= w_is_b;
              r_rd         <= w_is_b ? 5'd0 : w_instr[11:7];
            end else begin
              r_state       <= S_RESP;
              r_res_valid   <= 1'b1;
              r_res_illegal <= 1'b1;
            end
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - 4'd1;
          // The ALU result is only trusted on the edge the counter expires.
          if (r_cnt <= 4'd1) begin
            r_state            <= S_RESP;
            r_cnt              <= 4'd0;
            r_dat_ready        <= 1'b0;
            r_alu_dat1         <= 32'd0;
            r_alu_dat2         <= 32'd0;
            r_alu_opcode       <= 3'd0;
            r_alu_diff         <= 1'b0;
            r_alu_optype       <= 1'b0;
            r_res_valid        <= 1'b1;
            r_res_data         <= r_is_branch ? 32'd0 : bus.ALU_out;
            r_res_rd           <= r_rd;
            r_res_wb_en        <= !r_is_branch && (r_rd != 5'd0);
            r_res_branch_taken <= r_is_branch && bus.ALU_con_met;
            r_res_overflow     <= bus.ALU_overflow;
            r_res_zero         <= bus.ALU_zero;
            r_res_illegal      <= 1'b0;
          end
        end
        S_RESP: begin
          if (bus.res_ready) begin
            r_state            <= S_IDLE;
            r_instr_ready      <= 1'b1;
            r_res_valid        <= 1'b0;
            r_res_data         <= 32'd0;
            r_res_rd           <= 5'd0;
            r_res_wb_en        <= 1'b0;
            r_res_branch_taken <= 1'b0;
            r_res_overflow     <= 1'b0;
            r_res_zero         <= 1'b0;
            r_res_illegal      <= 1'b0;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_instr_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instr_ready               = r_instr_ready;
  assign bus.dat_ready                 = r_dat_ready;
  assign bus.ALU_dat1                  = r_alu_dat1;
  assign bus.ALU_dat2                  = r_alu_dat2;
  assign bus.ALU_opcode                = r_alu_opcode;
  assign bus.ALU_opcode_differentiator = r_alu_diff;
  assign bus.ALU_optype                = r_alu_optype;
  assign bus.res_valid                 = r_res_valid;
  assign bus.res_data                  = r_res_data;
  assign bus.res_rd                    = r_res_rd;
  assign bus.res_wb_en                 = r_res_wb_en;
  assign bus.res_branch_taken          = r_res_branch_taken;
  assign bus.res_overflow              = r_res_overflow;
  assign bus.res_zero                  = r_res_zero;
  assign bus.res_illegal               = r_res_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Brief    : Self-checking bench for alu_issue_ctrl against an ISA-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

  localparam int L = 3;

  logic soc_clk = 1'b0;
  logic reset_b = 1'b1;
  int   errors  = 0;
  int   checks  = 0;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl #(.ALU_LATENCY(L)) dut (
    .soc_clk (soc_clk),
    .reset_b (reset_b),
    .bus     (bus)
  );

  always #5 soc_clk = ~soc_clk;

  typedef struct packed {
    logic        illegal;
    logic [31:0] d2;
    logic [2:0]  op;
    logic        diff;
    logic        optype;
    logic [4:0]  rd;
    logic        wb;
    logic        br;
  } exp_t;

  // Instruction-set view: what the ALU should be asked and what comes back.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] r2);
    exp_t       e;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    f3 = ins[14:12];
    f7 = ins[31:25];
    rd = ins[11:7];
    e  = '0;
    e.op = f3;
    case (ins[6:0])
      7'h33: begin
        e.illegal = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        e.d2      = r2;
        e.diff    = (f3 == 3'd0 || f3 == 3'd5) ? f7[5] : 1'b0;
        e.rd      = rd;
        e.wb      = (rd != 5'd0);
      end
      7'h13: begin
        e.illegal = (f3 == 3'd1 && f7 != 7'h00) ||
                    (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
        if (f3 == 3'd1 || f3 == 3'd5) e.d2 = {27'd0, ins[24:20]};
        else e.d2 = {20'd0, ins[31:20]} - (ins[31] ? 32'd4096 : 32'd0);
        e.diff = (f3 == 3'd5) ? f7[5] : 1'b0;
        e.rd   = rd;
        e.wb   = (rd != 5'd0);
      end
      7'h63: begin
        e.illegal = (f3 == 3'd2 || f3 == 3'd3);
        e.d2      = r2;
        e.optype  = 1'b1;
        e.br      = 1'b1;
      end
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  task automatic run_instr(input string name, input logic [31:0] ins, input logic [31:0] r1,
                           input logic [31:0] r2, input bit fixed, input logic [31:0] fout,
                           input logic fcon, input int stall);
    exp_t        e;
    int          cnt;
    int          waitc;
    logic [31:0] cap_out;
    logic        cap_ov, cap_z, cap_con;
    logic [43:0] got, want;
    e = model(ins, r2);
    waitc = 0;
    while (bus.instr_ready !== 1'b1 && waitc < 20) begin
      @(negedge soc_clk);
      waitc++;
    end
    checks++;
    if (bus.instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s instr_ready_wait: got %b want 1", name, bus.instr_ready);
      return;
    end
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    bus.rs1_dat     = r1;
    bus.rs2_dat     = r2;
    @(negedge soc_clk);
    bus.instr_valid = 1'b0;
    bus.instr       = $urandom;
    bus.rs1_dat     = $urandom;
    bus.rs2_dat     = $urandom;
    cnt = 0;
    cap_out = '0; cap_ov = 1'b0; cap_z = 1'b0; cap_con = 1'b0;
    while (bus.dat_ready === 1'b1 && cnt < 20) begin
      checks++;
      if ({bus.ALU_dat1, bus.ALU_dat2, bus.ALU_opcode, bus.ALU_opcode_differentiator,
           bus.ALU_optype, bus.instr_ready, bus.res_valid} !==
          {r1, e.d2, e.op, e.diff, e.optype, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL %s alu_req cyc%0d: got d1=%h d2=%h op=%0d diff=%b ot=%b ir=%b rv=%b want d1=%h d2=%h op=%0d diff=%b ot=%b ir=0 rv=0",
                 name, cnt, bus.ALU_dat1, bus.ALU_dat2, bus.ALU_opcode,
                 bus.ALU_opcode_differentiator, bus.ALU_optype, bus.instr_ready, bus.res_valid,
                 r1, e.d2, e.op, e.diff, e.optype);
      end
      if (fixed) begin
        bus.ALU_out = fout; bus.ALU_con_met = fcon;
        bus.ALU_overflow = 1'b0; bus.ALU_zero = (fout == 32'd0);
      end else begin
        bus.ALU_out = $urandom;
        {bus.ALU_overflow, bus.ALU_zero, bus.ALU_con_met} = 3'($urandom);
      end
      cap_out = bus.ALU_out; cap_ov = bus.ALU_overflow;
      cap_z   = bus.ALU_zero; cap_con = bus.ALU_con_met;
      cnt++;
      @(negedge soc_clk);
    end
    bus.ALU_out = $urandom;
    {bus.ALU_overflow, bus.ALU_zero, bus.ALU_con_met} = 3'($urandom);
    checks++;
    if (cnt != (e.illegal ? 0 : L)) begin
      errors++;
      $display("FAIL %s dat_ready_len: got %0d want %0d", name, cnt, e.illegal ? 0 : L);
    end
    checks++;
    if ({bus.dat_ready, bus.ALU_dat1, bus.ALU_dat2, bus.ALU_opcode,
         bus.ALU_opcode_differentiator, bus.ALU_optype} !== '0) begin
      errors++;
      $display("FAIL %s alu_req_idle: got dr=%b d1=%h d2=%h op=%0d want all zero", name,
               bus.dat_ready, bus.ALU_dat1, bus.ALU_dat2, bus.ALU_opcode);
    end
    if (e.illegal) want = {1'b1, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    else want = {1'b1, (e.br ? 32'd0 : cap_out), e.rd, e.wb, (e.br & cap_con), cap_ov, cap_z,
                 1'b0, 1'b0};
    for (int s = 0; s <= stall; s++) begin
      got = {bus.res_valid, bus.res_data, bus.res_rd, bus.res_wb_en, bus.res_branch_taken,
             bus.res_overflow, bus.res_zero, bus.res_illegal, bus.instr_ready};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s res_fields stall%0d: got %h want %h", name, s, got, want);
      end
      bus.res_ready   = (s == stall);
      bus.instr_valid = (s != stall);
      @(negedge soc_clk);
    end
    bus.res_ready   = 1'b0;
    bus.instr_valid = 1'b0;
    checks++;
    if ({bus.res_valid, bus.instr_ready, bus.dat_ready} !== 3'b010) begin
      errors++;
      $display("FAIL %s release: got rv=%b ir=%b dr=%b want rv=0 ir=1 dr=0", name,
               bus.res_valid, bus.instr_ready, bus.dat_ready);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge soc_clk);
    checks++;
    if ({bus.instr_ready, bus.dat_ready, bus.ALU_dat1, bus.ALU_dat2, bus.ALU_opcode,
         bus.ALU_opcode_differentiator, bus.ALU_optype, bus.res_valid, bus.res_data,
         bus.res_rd, bus.res_wb_en, bus.res_branch_taken, bus.res_overflow, bus.res_zero,
         bus.res_illegal} !== '0) begin
      errors++;
      $display("FAIL reset_state: got ir=%b dr=%b rv=%b rd=%h want all zero",
               bus.instr_ready, bus.dat_ready, bus.res_valid, bus.res_data);
    end
    reset_b = 1'b0;
    #1;
    checks++;
    if (bus.instr_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_early: got instr_ready=%b want 0", bus.instr_ready);
    end
    @(negedge soc_clk);
    checks++;
    if (bus.instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got instr_ready=%b want 1", bus.instr_ready);
    end
  endtask

  task automatic test_add;
    run_instr("add", 32'h002081B3, 32'd5, 32'd7, 1'b1, 32'd12, 1'b0, 5);
  endtask

  task automatic test_srai;
    run_instr("srai", 32'h4040D213, 32'h80000000, 32'h1234, 1'b1, 32'hF8000000, 1'b0, 0);
  endtask

  task automatic test_bne;
    run_instr("bne", 32'h00209463, 32'd1, 32'd2, 1'b1, 32'hFFFFFFFF, 1'b1, 1);
  endtask

  task automatic test_addi;
    run_instr("addi", 32'hFFF08293, 32'd9, 32'h55, 1'b1, 32'd8, 1'b0, 0);
  endtask

  task automatic test_illegal;
    run_instr("illegal_load", 32'h0000A183, 32'd3, 32'd4, 1'b1, 32'd1, 1'b0, 1);
    run_instr("illegal_r", 32'h4020C1B3, 32'd3, 32'd4, 1'b0, 32'd0, 1'b0, 0);
  endtask

  task automatic test_mid_reset;
    bus.instr_valid = 1'b1;
    bus.instr       = 32'h002081B3;
    bus.rs1_dat     = 32'hA5A5A5A5;
    bus.rs2_dat     = 32'h1;
    @(negedge soc_clk);
    bus.instr_valid = 1'b0;
    @(negedge soc_clk);
    checks++;
    if (bus.dat_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_busy: got dat_ready=%b want 1", bus.dat_ready);
    end
    reset_b = 1'b1;
    #1;
    checks++;
    if ({bus.dat_ready, bus.ALU_dat1, bus.ALU_dat2, bus.ALU_opcode, bus.ALU_optype,
         bus.instr_ready, bus.res_valid} !== '0) begin
      errors++;
      $display("FAIL midreset_async: got dr=%b d1=%h ir=%b rv=%b want all zero",
               bus.dat_ready, bus.ALU_dat1, bus.instr_ready, bus.res_valid);
    end
    @(negedge soc_clk);
    reset_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge soc_clk);
      checks++;
      if (bus.res_valid !== 1'b0 || bus.dat_ready !== 1'b0) begin
        errors++;
        $display("FAIL midreset_no_result cyc%0d: got rv=%b dr=%b want 0 0", i,
                 bus.res_valid, bus.dat_ready);
      end
    end
    checks++;
    if (bus.instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready: got instr_ready=%b want 1", bus.instr_ready);
    end
  endtask

  task automatic test_back_to_back;
    int   first, second, waitc;
    logic prev;
    bus.res_ready   = 1'b1;
    bus.instr_valid = 1'b1;
    bus.instr       = 32'h002081B3;
    first  = -1;
    second = -1;
    prev   = bus.dat_ready;
    for (int cyc = 0; cyc < 40 && second < 0; cyc++) begin
      @(negedge soc_clk);
      if (bus.dat_ready === 1'b1 && prev === 1'b0) begin
        if (first < 0) first = cyc;
        else second = cyc;
      end
      prev = bus.dat_ready;
    end
    bus.instr_valid = 1'b0;
    checks++;
    if (first < 0 || second < 0 || (second - first) != L + 2) begin
      errors++;
      $display("FAIL back_to_back_period: got %0d want %0d", second - first, L + 2);
    end
    waitc = 0;
    while (!(bus.instr_ready === 1'b1 && bus.res_valid === 1'b0 && bus.dat_ready === 1'b0)
           && waitc < 30) begin
      @(negedge soc_clk);
      waitc++;
    end
    bus.res_ready = 1'b0;
    checks++;
    if (waitc >= 30) begin
      errors++;
      $display("FAIL back_to_back_drain: got timeout after %0d cycles want idle", waitc);
    end
  endtask

  task automatic test_random;
    logic [31:0] ins;
    for (int n = 0; n < 40; n++) begin
      ins = $urandom;
      case ($urandom_range(0, 3))
        0:       ins[6:0] = 7'h33;
        1:       ins[6:0] = 7'h13;
        2:       ins[6:0] = 7'h63;
        default: ins[6:0] = 7'($urandom);
      endcase
      case ($urandom_range(0, 2))
        0:       ins[31:25] = 7'h00;
        1:       ins[31:25] = 7'h20;
        default: ins[31:25] = 7'($urandom);
      endcase
      run_instr("random", ins, $urandom, $urandom, 1'b0, 32'd0, 1'b0, $urandom_range(0, 2));
    end
  endtask

  initial begin
    bus.instr_valid  = 1'b0;
    bus.instr        = '0;
    bus.rs1_dat      = '0;
    bus.rs2_dat      = '0;
    bus.ALU_out      = '0;
    bus.ALU_overflow = 1'b0;
    bus.ALU_zero     = 1'b0;
    bus.ALU_con_met  = 1'b0;
    bus.res_ready    = 1'b0;
    test_reset;
    test_add;
    test_srai;
    test_bne;
    test_addi;
    test_illegal;
    test_mid_reset;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter ALU_LATENCY, default 3, meaning soc_clk cycles dat_ready is held before ALU results are sampled (legal 1..15).
REQ-002 SHALL have port soc_clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port reset_b  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports instr_valid input 1 / instr_ready output 1: instruction handshake; transfer when both high at a rising edge.
REQ-005 SHALL have ports instr input 32, rs1_dat input 32, rs2_dat input 32: instruction word and register-file operands, sampled on transfer.
REQ-006 SHALL have ports dat_ready output 1, ALU_dat1 output 32, ALU_dat2 output 32, ALU_opcode output 3, ALU_opcode_differentiator output 1, ALU_optype output 1: ALU request.
REQ-007 SHALL have ports ALU_out input 32, ALU_overflow input 1, ALU_zero input 1, ALU_con_met input 1: ALU result.
REQ-008 SHALL have ports res_valid output 1 / res_ready input 1: result handshake.
REQ-009 SHALL have ports res_data output 32, res_rd output 5, res_wb_en output 1, res_branch_taken output 1, res_overflow output 1, res_zero output 1, res_illegal output 1: registered result fields, stable while res_valid high.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY, RESP; instr_ready high only in IDLE.
REQ-011 SHALL decode instr[6:0]: 0110011 R, 0010011 I, 1100011 B; any other opcode illegal.
REQ-012 SHALL treat as illegal: R with funct7 not 0000000/0100000, or 0100000 with funct3 not 000/101; I funct3 001 with instr[31:25]!=0; I funct3 101 with instr[31:25] not 0000000/0100000; B funct3 010/011.
REQ-013 SHALL on legal transfer: IDLE->BUSY, dat_ready=1, ALU_dat1=rs1_dat, ALU_dat2=rs2_dat (R,B) or sign-extended instr[31:20] (I; shifts use zero-extended instr[24:20]), ALU_opcode=instr[14:12].
REQ-014 SHALL drive ALU_optype=1 for B, 0 for R/I.
REQ-015 SHALL drive ALU_opcode_differentiator=instr[30] for R funct3 000 and R/I funct3 101; 0 otherwise (ADDI never subtracts).
REQ-016 SHALL hold all ALU request outputs constant for exactly ALU_LATENCY cycles in BUSY, counted by a 4-bit down-counter.
REQ-017 SHALL on the edge where counter reaches zero: sample ALU_out/flags into res_*, deassert dat_ready, zero ALU request outputs, BUSY->RESP.
REQ-018 SHALL set res_rd=instr[11:7] and res_wb_en=1 for R/I, res_rd=0 and res_wb_en=0 for B; res_wb_en=0 when instr[11:7]=0.
REQ-019 SHALL set res_branch_taken=ALU_con_met for B, 0 otherwise; res_data=ALU_out for R/I, 0 for B.
REQ-020 SHALL on illegal transfer: no ALU request (dat_ready stays 0), IDLE->RESP next edge, res_illegal=1, all other res_* 0.
REQ-021 SHALL assert res_valid only in RESP; RESP->IDLE on edge with res_ready=1; hold all res_* while res_ready=0.
REQ-022 SHALL present dat_ready as a clean pulse: rising edge at BUSY entry, falling edge at BUSY exit, never glitch.
REQ-023 SHALL accept no new instruction in BUSY/RESP; back-to-back throughput one instruction per ALU_LATENCY+2 cycles with res_ready tied high.
REQ-024 SHALL ignore ALU inputs outside the sampling edge.

Reset
REQ-025 SHALL on reset_b=1 immediately force IDLE, counter=0, dat_ready=0, all ALU request outputs 0, res_valid=0, all res_* 0, instr_ready=0 while reset asserted.
REQ-026 SHALL abort any in-flight request on mid-operation reset; no result is ever delivered for it.
REQ-027 SHALL raise instr_ready on first rising edge after reset_b deasserts.

Verification
REQ-028 SHALL cover ADD x3,x1,x2 (rs1=5, rs2=7), ALU_out=12 at sampling edge -> dat_ready high 3 cycles, opcode 000, diff 0, optype 0; res_data=12, res_rd=3, res_wb_en=1.
REQ-029 SHALL cover SRAI x4,x1,4 (rs1=0x80000000) -> ALU_dat2=4, diff=1, opcode 101; res_data=ALU_out.
REQ-030 SHALL cover BNE (rs1=1, rs2=2), ALU_con_met=1 -> optype=1, opcode 001; res_branch_taken=1, res_wb_en=0, res_data=0.
REQ-031 SHALL cover ADDI imm=0xFFF -> ALU_dat2=0xFFFFFFFF, diff=0 even with instr[30]=1.
REQ-032 SHALL cover illegal opcode 0000011 -> dat_ready never rises, res_valid next cycle with res_illegal=1.
REQ-033 SHALL cover reset_b pulse in 2nd BUSY cycle and res_ready held low 5 cycles -> immediate dat_ready=0, no res_valid; res_* stable during stall.
